// File: rtl/rggen_mux_arbiter.sv
// rggen_mux_arbiter
//
// Round-robin arbiter for one shared read-data path, such as an rggen_mux, or for any
// other resource that has a single owner at a time. The registered one-hot grant can
// drive the mux i_select directly. A grant is held until the owner signals i_done,
// drops its request, or the optional watchdog expires. Every release is followed by
// at least one idle cycle.
//
// Parameters
//   REQUESTERS     : number of requesting agents (1..32)
//   TIMEOUT_CYCLES : maximum number of cycles a grant may be held without i_done;
//                    0 disables the watchdog (0..65535)
//
// Ports
//   i_clk         : clock; all logic runs on the rising edge
//   i_rst         : synchronous reset, active-high
//   i_request     : per-requester level request; bit i belongs to requester i
//   i_done        : the current owner's transfer is complete; only looked at while granted
//   o_grant       : registered one-hot grant; all-zero when idle
//   o_grant_index : binary index of the current or most recent grantee
//   o_busy        : high while a grant is active
//   o_timeout     : one-cycle pulse in the first idle cycle after a watchdog release

module rggen_mux_arbiter #(
  parameter int unsigned REQUESTERS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  localparam int unsigned INDEX_WIDTH   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [REQUESTERS-1:0]  i_request,
  input  logic                   i_done,
  output logic [REQUESTERS-1:0]  o_grant,
  output logic [INDEX_WIDTH-1:0] o_grant_index,
  output logic                   o_busy,
  output logic                   o_timeout
);

  // Requester count, widened by one bit so that ptr + offset fits without overflow.
  localparam logic [INDEX_WIDTH:0] NUM_REQ      = REQUESTERS[INDEX_WIDTH:0];
  localparam logic [15:0]          TIMEOUT_LAST = TIMEOUT_CYCLES[15:0] - 16'd1;
  localparam bit                   WD_ENABLE    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                 state_q, state_d;
  logic [REQUESTERS-1:0]  grant_q, grant_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [15:0]            count_q, count_d;
  logic                   timeout_q, timeout_d;

  // Round-robin search: rotate the requests so that bit 0 is the one at ptr,
  // take the lowest set bit, then map that offset back to an absolute index.
  logic [2*REQUESTERS-1:0] req_dbl;
  logic [2*REQUESTERS-1:0] req_rot;
  logic                    found;
  logic [INDEX_WIDTH-1:0]  sel;
  logic [INDEX_WIDTH:0]    sel_sum;

  assign req_dbl = {i_request, i_request};
  assign req_rot = req_dbl >> ptr_q;

  always_comb begin
    found   = 1'b0;
    sel     = '0;
    sel_sum = '0;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      if (!found && req_rot[k]) begin
        found   = 1'b1;
        sel_sum = {1'b0, ptr_q} + k[INDEX_WIDTH:0];
        if (sel_sum >= NUM_REQ) begin
          sel_sum = sel_sum - NUM_REQ;
        end
        sel = sel_sum[INDEX_WIDTH-1:0];
      end
    end
  end

  // The pointer after a release is (owner + 1) mod REQUESTERS.
  logic [INDEX_WIDTH:0]   next_sum;
  logic [INDEX_WIDTH-1:0] next_ptr;

  always_comb begin
    next_sum = {1'b0, index_q} + {{INDEX_WIDTH{1'b0}}, 1'b1};
    if (next_sum >= NUM_REQ) begin
      next_sum = next_sum - NUM_REQ;
    end
    next_ptr = next_sum[INDEX_WIDTH-1:0];
  end

  logic owner_req;
  logic wd_hit;

  assign owner_req = |(i_request & grant_q);
  assign wd_hit    = WD_ENABLE && (count_q == TIMEOUT_LAST);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      index_q   <= '0;
      ptr_q     <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      index_q   <= index_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    index_d   = index_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d      = StGrant;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          index_d      = sel;
          count_d      = '0;
        end
      end

      StGrant: begin
        // Release priority: done, then abort, then watchdog.
        if (i_done || !owner_req || wd_hit) begin
          state_d   = StIdle;
          grant_d   = '0;
          ptr_d     = next_ptr;
          timeout_d = !i_done && owner_req;
        end else if (count_q != 16'hffff) begin
          count_d = count_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_grant       = grant_q;
    o_grant_index = index_q;
    o_busy        = (state_q == StGrant);
    o_timeout     = timeout_q;
  end

  // The grant must never be multi-hot.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert ($onehot0(grant_q));
    end
  end

endmodule

// File: tb/tb_rggen_mux_arbiter.sv
module tb_rggen_mux_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] gidx;
  logic       busy;
  logic       tmo;

  int vectors     = 0;
  int miscompares = 0;

  rggen_mux_arbiter #(
    .REQUESTERS     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_request     (req),
    .i_done        (done),
    .o_grant       (grant),
    .o_grant_index (gidx),
    .o_busy        (busy),
    .o_timeout     (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] i,
                            input logic b, input logic t);
    check({tag, ".grant"}, {28'd0, grant}, {28'd0, g});
    check({tag, ".index"}, {30'd0, gidx}, {30'd0, i});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, ".timeout"}, {31'd0, tmo}, {31'd0, t});
  endtask

  // Grant g/i is visible now; hold one cycle, pulse done, and check the release.
  task automatic grant_cycle(input string tag, input logic [3:0] g, input logic [1:0] i);
    expect_out({tag, ".on"}, g, i, 1'b1, 1'b0);
    tick();
    expect_out({tag, ".hold"}, g, i, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    expect_out({tag, ".rel"}, 4'b0000, i, 1'b0, 1'b0);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;

    // Reset with all requests asserted
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("rst%0d", k), 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    req = 4'b0000;
    tick();
    expect_out("idle0", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("idle1", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Round-robin rotation
    req = 4'b1111;
    tick();
    grant_cycle("rr0", 4'b0001, 2'd0);
    tick();
    grant_cycle("rr1", 4'b0010, 2'd1);
    tick();
    grant_cycle("rr2", 4'b0100, 2'd2);
    tick();
    grant_cycle("rr3", 4'b1000, 2'd3);
    tick();
    grant_cycle("rr4", 4'b0001, 2'd0);

    // Wrap and skip: ptr=3 after owner 2 releases, so 0011 goes to 0
    tick();
    grant_cycle("ws1", 4'b0010, 2'd1);
    tick();
    grant_cycle("ws2", 4'b0100, 2'd2);
    req = 4'b0011;
    tick();
    grant_cycle("ws0", 4'b0001, 2'd0);
    req = 4'b0010;
    tick();
    expect_out("ws_g1", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Abort: owner 1 drops its request
    tick();
    expect_out("ab_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0001;
    tick();
    expect_out("ab_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
    req = 4'b0011;
    tick();
    expect_out("ab_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    expect_out("ab_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Watchdog: ptr=1, owner 1 holds 8 cycles without done
    req = 4'b0011;
    tick();
    for (int k = 0; k < 8; k++) begin
      expect_out($sformatf("wd_c%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
      tick();
    end
    expect_out("wd_fire", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick();
    expect_out("wd_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 1; k < 7; k++) begin
      tick();
      expect_out($sformatf("wd2_c%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    expect_out("wd2_c7", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    expect_out("wd2_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Done while idle has no effect
    req  = 4'b0000;
    done = 1'b1;
    tick();
    done = 1'b0;
    expect_out("idle_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset mid-grant: owner 3 at count 5
    req = 4'b1000;
    tick();
    expect_out("mr_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    expect_out("mr_c5", 4'b1000, 2'd3, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("mr_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1001;
    tick();
    expect_out("mr_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    expect_out("mr_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
